// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel/line position, active-video flag and lock
// status from free-running active-low hsync/vsync inputs. Both syncs are
// synchronized into clk_i; only their falling edges are used.
module vga_sync_decoder #(
    parameter int H_DISPLAY  = 640,
    parameter int H_TOTAL    = 784,
    parameter int V_DISPLAY  = 480,
    parameter int V_TOTAL    = 502,
    parameter int H_EDGE_POS = 651,
    parameter int V_EDGE_POS = 494,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [9:0]  hpos_o,
    output logic [8:0]  vpos_o,
    output logic        display_on_o,
    output logic        locked_o,
    output logic [10:0] line_len_o,
    output logic [9:0]  frame_lines_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } h_state_e;

    localparam logic [10:0] HPER_MAX   = 11'h7FF;
    localparam logic [9:0]  LCNT_MAX   = 10'h3FF;
    localparam logic [10:0] H_TOTAL_M1 = 11'(H_TOTAL - 1);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_EDGE     = 10'(H_EDGE_POS);
    localparam logic [9:0]  H_DISP_L   = 10'(H_DISPLAY);
    localparam logic [8:0]  V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_EDGE     = 9'(V_EDGE_POS);
    localparam logic [8:0]  V_DISP_L   = 9'(V_DISPLAY);
    localparam logic [9:0]  V_TOTAL_L  = 10'(V_TOTAL);
    localparam logic [2:0]  LOCK_L     = 3'(LOCK_LINES);

    // bit 0 = hsync, bit 1 = vsync
    logic [1:0] sync_raw;
    logic [1:0] sync_det;
    logic       hsync_det;
    logic       vsync_det;

    assign sync_raw  = {vsync_i, hsync_i};
    assign hsync_det = sync_det[0];
    assign vsync_det = sync_det[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic s3_reg;

            // Two-flop synchronizer plus history flop; idle (high) in reset so
            // the first edge after release is seen from a clean history.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                    s3_reg <= 1'b1;
                end else begin
                    s1_reg <= sync_raw[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                end
            end

            assign sync_det[gi] = s3_reg & ~s2_reg;
        end
    endgenerate

    h_state_e    state_reg, state_next;
    logic [2:0]  gcnt_reg, gcnt_next;
    logic [10:0] hper_reg, hper_next;
    logic [9:0]  lcnt_reg, lcnt_next;
    logic [9:0]  hpos_reg, hpos_next;
    logic [8:0]  vpos_reg, vpos_next;
    logic [10:0] line_len_reg, line_len_next;
    logic [9:0]  frame_lines_reg, frame_lines_next;
    logic        vlock_reg, vlock_next;
    logic        locked_reg, locked_next;
    logic        display_reg, display_next;
    logic        err_reg, err_next;

    logic [10:0] hper_sat;
    logic [9:0]  lcnt_sat;
    logic        line_match;
    logic        hsync_timeout;

    assign hper_sat      = (hper_reg == HPER_MAX) ? HPER_MAX : hper_reg + 11'd1;
    assign lcnt_sat      = (lcnt_reg == LCNT_MAX) ? LCNT_MAX : lcnt_reg + 10'd1;
    assign line_match    = hsync_det && (hper_reg == H_TOTAL_M1);
    assign hsync_timeout = (hper_reg == HPER_MAX);

    // Horizontal lock FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= SEARCH;
            gcnt_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            gcnt_reg  <= gcnt_next;
        end
    end

    // Horizontal lock FSM: count good lines, drop out on a bad line or timeout.
    always_comb begin
        state_next = state_reg;
        gcnt_next  = gcnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (hsync_det) begin
                    state_next = MEASURE;
                    gcnt_next  = 3'd0;
                end
            end
            MEASURE: begin
                if (hsync_timeout) begin
                    state_next = SEARCH;
                    gcnt_next  = 3'd0;
                end else if (hsync_det) begin
                    if (line_match) begin
                        gcnt_next = gcnt_reg + 3'd1;
                        if (gcnt_reg + 3'd1 == LOCK_L) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        gcnt_next = 3'd0;
                    end
                end
            end
            LOCKED: begin
                if (hsync_timeout || (hsync_det && !line_match)) begin
                    state_next = SEARCH;
                    gcnt_next  = 3'd0;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
                gcnt_next  = 3'd0;
            end
        endcase
    end

    // Period/line counters and recovered position.
    always_comb begin
        hper_next        = hsync_det ? 11'd0 : hper_sat;
        line_len_next    = hsync_det ? hper_sat : line_len_reg;
        lcnt_next        = hsync_det ? lcnt_sat : lcnt_reg;
        frame_lines_next = frame_lines_reg;
        hpos_next        = hpos_reg;
        vpos_next        = vpos_reg;

        if (vsync_det) begin
            // A coincident hsync edge still belongs to the frame being closed.
            frame_lines_next = hsync_det ? lcnt_sat : lcnt_reg;
            lcnt_next        = 10'd0;
        end

        if (hsync_det) begin
            hpos_next = H_EDGE;
        end else if (hpos_reg == H_LAST) begin
            hpos_next = 10'd0;
        end else begin
            hpos_next = hpos_reg + 10'd1;
        end

        if (vsync_det) begin
            vpos_next = V_EDGE;
        end else if (!hsync_det && hpos_reg == H_LAST) begin
            vpos_next = (vpos_reg == V_LAST) ? 9'd0 : vpos_reg + 9'd1;
        end
    end

    // Vertical lock and the status flags aligned with hpos/vpos.
    always_comb begin
        vlock_next = vlock_reg;
        if (vsync_det) begin
            vlock_next = (frame_lines_next == V_TOTAL_L);
        end
        if (state_reg == LOCKED && state_next != LOCKED) begin
            vlock_next = 1'b0;
        end
        locked_next  = (state_next == LOCKED) && vlock_next;
        display_next = locked_next && (hpos_next < H_DISP_L) && (vpos_next < V_DISP_L);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hper_reg        <= 11'd0;
            lcnt_reg        <= 10'd0;
            hpos_reg        <= 10'd0;
            vpos_reg        <= 9'd0;
            line_len_reg    <= 11'd0;
            frame_lines_reg <= 10'd0;
            vlock_reg       <= 1'b0;
            locked_reg      <= 1'b0;
            display_reg     <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            hper_reg        <= hper_next;
            lcnt_reg        <= lcnt_next;
            hpos_reg        <= hpos_next;
            vpos_reg        <= vpos_next;
            line_len_reg    <= line_len_next;
            frame_lines_reg <= frame_lines_next;
            vlock_reg       <= vlock_next;
            locked_reg      <= locked_next;
            display_reg     <= display_next;
            err_reg         <= err_next;
        end
    end

    assign hpos_o        = hpos_reg;
    assign vpos_o        = vpos_reg;
    assign display_on_o  = display_reg;
    assign locked_o      = locked_reg;
    assign line_len_o    = line_len_reg;
    assign frame_lines_o = frame_lines_reg;
    assign err_o         = err_reg;

endmodule
